// File: rtl/apu_timer_pkg.sv
// rtl/apu_timer_pkg.sv - register map constants shared by the APU timer bank
package apu_timer_pkg;

    localparam int REG_CONTROL       = 0;
    localparam int REG_RATE          = 1;
    localparam int REG_IRQ_EN        = 2;
    localparam int REG_STATUS        = 3;
    localparam int REG_INTERVAL_BASE = 4;

    // Counters sit after the interval block; callers pass NUM_TIMERS + channel.
    function automatic int counter_offset(input int n);
        return REG_INTERVAL_BASE + n;
    endfunction

endpackage

// File: rtl/apu_timer_ch.sv
// rtl/apu_timer_ch.sv - one timer channel: interval compare, read-to-clear counter, overflow pulse
module apu_timer_ch #(
    parameter int COUNTER_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stage_tick,
    input  logic                 enable_rise,
    input  logic                 read_clear,
    input  logic [7:0]           interval,
    output logic [COUNTER_W-1:0] counter,
    output logic                 overflow
);

    logic [7:0]           timer_q, timer_d;
    logic [COUNTER_W-1:0] counter_q, counter_d;
    logic                 match;

    always_comb begin
        timer_d   = timer_q;
        counter_d = counter_q;
        overflow  = 1'b0;
        // Modular compare: interval 0 matches at 255, giving a 256-tick period.
        match     = stage_tick && (timer_q == (interval - 8'd1));

        if (stage_tick) begin
            timer_d = match ? 8'd0 : timer_q + 8'd1;
        end

        if (read_clear) begin
            // The read consumed the old value; a coincident increment survives as 1.
            counter_d = match ? COUNTER_W'(1) : '0;
        end else if (match) begin
            counter_d = counter_q + COUNTER_W'(1);
            overflow  = &counter_q;
        end

        if (enable_rise) begin
            timer_d   = 8'd0;
            counter_d = '0;
            overflow  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q   <= 8'd0;
            counter_q <= '0;
        end else begin
            timer_q   <= timer_d;
            counter_q <= counter_d;
        end
    end

    assign counter = counter_q;

endmodule

// File: rtl/apu_timer_bank.sv
// rtl/apu_timer_bank.sv - prescaled timer bank: prescaler, register decode, status, irq, read mux
module apu_timer_bank
    import apu_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 3,
    parameter int COUNTER_W  = 4,
    parameter int PRESCALE_W = 7,
    parameter int FAST_W     = 4,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              write,
    input  logic              read,
    output logic [7:0]        rdata,
    output logic              irq
);

    logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
    logic [NUM_TIMERS-1:0] enable_q, enable_d;
    logic [NUM_TIMERS-1:0] rate_q, rate_d;
    logic [NUM_TIMERS-1:0] irq_en_q, irq_en_d;
    logic [NUM_TIMERS-1:0] status_q, status_d;
    logic [7:0]            interval_q [NUM_TIMERS];
    logic [7:0]            interval_d [NUM_TIMERS];
    logic                  irq_q, irq_d;

    logic                  ctrl_wr;
    logic                  slow_tick, fast_tick;
    logic [NUM_TIMERS-1:0] enable_rise, stage_tick, read_clear, overflow;
    logic [COUNTER_W-1:0]  counter [NUM_TIMERS];

    assign ctrl_wr   = write && (addr == ADDR_W'(REG_CONTROL));
    assign slow_tick = tick_en && (&prescaler_q);
    assign fast_tick = tick_en && (&prescaler_q[FAST_W-1:0]);

    always_comb begin
        prescaler_d = prescaler_q;
        enable_d    = enable_q;
        rate_d      = rate_q;
        irq_en_d    = irq_en_q;
        interval_d  = interval_q;
        enable_rise = '0;

        if (ctrl_wr) begin
            prescaler_d = '0;
            enable_d    = wdata[NUM_TIMERS-1:0];
            enable_rise = wdata[NUM_TIMERS-1:0] & ~enable_q;
        end else if (tick_en) begin
            prescaler_d = prescaler_q + PRESCALE_W'(1);
        end

        if (write && (addr == ADDR_W'(REG_RATE)))   rate_d   = wdata[NUM_TIMERS-1:0];
        if (write && (addr == ADDR_W'(REG_IRQ_EN))) irq_en_d = wdata[NUM_TIMERS-1:0];
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (write && (addr == ADDR_W'(REG_INTERVAL_BASE + i))) interval_d[i] = wdata;
        end

        // Set wins over a simultaneous write-1-to-clear.
        status_d = status_q & ~((write && (addr == ADDR_W'(REG_STATUS)))
                                ? wdata[NUM_TIMERS-1:0] : '0);
        status_d = status_d | overflow;
        irq_d    = |(status_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_q <= '0;
            enable_q    <= '0;
            rate_q      <= '0;
            irq_en_q    <= '0;
            status_q    <= '0;
            interval_q  <= '{default: 8'd0};
            irq_q       <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            enable_q    <= enable_d;
            rate_q      <= rate_d;
            irq_en_q    <= irq_en_d;
            status_q    <= status_d;
            interval_q  <= interval_d;
            irq_q       <= irq_d;
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
        assign stage_tick[g] = enable_q[g] && (rate_q[g] ? fast_tick : slow_tick);
        assign read_clear[g] = read && (addr == ADDR_W'(counter_offset(NUM_TIMERS + g)));

        apu_timer_ch #(
            .COUNTER_W (COUNTER_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .stage_tick  (stage_tick[g]),
            .enable_rise (enable_rise[g]),
            .read_clear  (read_clear[g]),
            .interval    (interval_q[g]),
            .counter     (counter[g]),
            .overflow    (overflow[g])
        );
    end

    always_comb begin
        rdata = 8'd0;
        if (addr == ADDR_W'(REG_CONTROL))     rdata = 8'(enable_q);
        else if (addr == ADDR_W'(REG_RATE))   rdata = 8'(rate_q);
        else if (addr == ADDR_W'(REG_IRQ_EN)) rdata = 8'(irq_en_q);
        else if (addr == ADDR_W'(REG_STATUS)) rdata = 8'(status_q);
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (addr == ADDR_W'(REG_INTERVAL_BASE + i))          rdata = interval_q[i];
            if (addr == ADDR_W'(counter_offset(NUM_TIMERS + i))) rdata = 8'(counter[i]);
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_apu_timer_bank.sv
// tb/tb_apu_timer_bank.sv - self-checking bench for apu_timer_bank
module tb_apu_timer_bank;

    localparam int NT = 3;
    localparam int CW = 4;
    localparam int PW = 7;
    localparam int FW = 4;
    localparam int AW = 5;
    localparam int CNT_BASE = 4 + NT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    wdata = 8'd0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [7:0]    rdata;
    logic          irq;

    always #5 clk = ~clk;

    apu_timer_bank #(
        .NUM_TIMERS (NT),
        .COUNTER_W  (CW),
        .PRESCALE_W (PW),
        .FAST_W     (FW),
        .ADDR_W     (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_en (tick_en),
        .addr    (addr),
        .wdata   (wdata),
        .write   (write),
        .read    (read),
        .rdata   (rdata),
        .irq     (irq)
    );

    int n_err = 0;
    int n_chk = 0;
    int obs_rd;
    int obs_irq;

    // Reference model: plain integers stepped by the register-level rules.
    int m_pre;
    int m_en[NT], m_rate[NT], m_ie[NT], m_st[NT], m_intv[NT], m_tmr[NT], m_cnt[NT];
    int m_irq;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_irq = 0;
        for (int i = 0; i < NT; i++) begin
            m_en[i] = 0; m_rate[i] = 0; m_ie[i] = 0; m_st[i] = 0;
            m_intv[i] = 0; m_tmr[i] = 0; m_cnt[i] = 0;
        end
    endtask

    function automatic int pack(input int v[NT]);
        int s = 0;
        for (int i = 0; i < NT; i++) s += (v[i] != 0) ? (1 << i) : 0;
        return s;
    endfunction

    function automatic int model_rdata(input int a);
        if (a == 0) return pack(m_en);
        if (a == 1) return pack(m_rate);
        if (a == 2) return pack(m_ie);
        if (a == 3) return pack(m_st);
        if (a >= 4 && a < CNT_BASE) return m_intv[a-4];
        if (a >= CNT_BASE && a < CNT_BASE + NT) return m_cnt[a-CNT_BASE];
        return 0;
    endfunction

    task automatic model_step(input bit w, input bit r, input int a, input int d, input bit t);
        bit fast, slow, stg, hit, ovf;
        int irq_next = 0;
        fast = t && (m_pre % 16 == 15);
        slow = t && (m_pre == 127);
        for (int i = 0; i < NT; i++) if (m_st[i] != 0 && m_ie[i] != 0) irq_next = 1;
        for (int i = 0; i < NT; i++) begin
            ovf = 0;
            stg = (m_en[i] != 0) && ((m_rate[i] != 0) ? fast : slow);
            hit = stg && (m_tmr[i] == (m_intv[i] + 255) % 256);
            if (stg) m_tmr[i] = hit ? 0 : (m_tmr[i] + 1) % 256;
            if (r && a == CNT_BASE + i) m_cnt[i] = hit ? 1 : 0;
            else if (hit) begin
                m_cnt[i]++;
                if (m_cnt[i] == (1 << CW)) begin m_cnt[i] = 0; ovf = 1; end
            end
            if (w && a == 0 && ((d >> i) & 1) != 0 && m_en[i] == 0) begin
                m_tmr[i] = 0; m_cnt[i] = 0; ovf = 0;
            end
            if (w && a == 3 && ((d >> i) & 1) != 0) m_st[i] = 0;
            if (ovf) m_st[i] = 1;
        end
        m_irq = irq_next;
        m_pre = (w && a == 0) ? 0 : (t ? (m_pre + 1) % 128 : m_pre);
        for (int i = 0; i < NT; i++) begin
            if (w && a == 0) m_en[i]   = (d >> i) & 1;
            if (w && a == 1) m_rate[i] = (d >> i) & 1;
            if (w && a == 2) m_ie[i]   = (d >> i) & 1;
            if (w && a == 4 + i) m_intv[i] = d & 255;
        end
    endtask

    task automatic cyc(input bit w, input bit r, input int a, input int d, input bit t);
        write = w; read = r; addr = a[AW-1:0]; wdata = d[7:0]; tick_en = t;
        @(negedge clk);
        obs_rd  = rdata;
        obs_irq = irq;
        chk("model_rdata", obs_rd, model_rdata(a));
        chk("model_irq", obs_irq, m_irq);
        model_step(w, r, a, d, t);
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0; tick_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(0, 0, 0, 0, 1);
    endtask

    task automatic wr(input int a, input int d);
        cyc(1, 0, a, d, 0);
    endtask

    task automatic rd_chk(input string name, input int a, input int exp);
        cyc(0, 1, a, 0, 0);
        chk(name, obs_rd, exp);
    endtask

    task automatic async_reset();
        addr = '0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("reset_async_rdata", rdata, 0);
        chk("reset_async_irq", irq, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit w;
        bit r;
        int a;
        int d;
        int exp_rd;
        int exp_irq;
    } vec_t;

    vec_t vecs[$];

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Register access table: rdata is the pre-edge value at that cycle's addr.
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{1, 0, 1, 8'hFF, 8'h00, 0});
        vecs.push_back('{0, 1, 1, 0, 8'h07, 0});
        vecs.push_back('{1, 0, 2, 8'hAA, 8'h00, 0});
        vecs.push_back('{0, 1, 2, 0, 8'h02, 0});
        vecs.push_back('{1, 0, 4, 8'h5C, 8'h00, 0});
        vecs.push_back('{0, 1, 4, 0, 8'h5C, 0});
        vecs.push_back('{1, 0, 6, 8'h33, 8'h00, 0});
        vecs.push_back('{0, 1, 6, 0, 8'h33, 0});
        vecs.push_back('{1, 0, 7, 8'hFF, 8'h00, 0});
        vecs.push_back('{0, 1, 7, 0, 8'h00, 0});
        vecs.push_back('{1, 0, 3, 8'hFF, 8'h00, 0});
        vecs.push_back('{0, 1, 3, 0, 8'h00, 0});
        vecs.push_back('{1, 0, 20, 8'hFF, 8'h00, 0});
        vecs.push_back('{0, 1, 20, 0, 8'h00, 0});
        vecs.push_back('{0, 1, 31, 0, 8'h00, 0});
        vecs.push_back('{1, 0, 0, 8'hF8, 8'h00, 0});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{1, 0, 0, 8'h05, 8'h00, 0});
        vecs.push_back('{0, 1, 0, 0, 8'h05, 0});
        foreach (vecs[k]) begin
            cyc(vecs[k].w, vecs[k].r, vecs[k].a, vecs[k].d, 0);
            chk($sformatf("vec%0d_rdata", k), obs_rd, vecs[k].exp_rd);
            chk($sformatf("vec%0d_irq", k), obs_irq, vecs[k].exp_irq);
        end

        // Reset mid-count.
        wr(4, 1); wr(1, 1); wr(2, 1); wr(0, 1);
        ticks(40);
        async_reset();
        for (int a = 0; a < CNT_BASE + NT; a++) rd_chk($sformatf("reset_reg%0d", a), a, 0);
        chk("reset_irq", obs_irq, 0);
        ticks(1000);
        rd_chk("idle_counter0", CNT_BASE, 0);

        // Slow rate.
        wr(4, 2); wr(0, 1);
        ticks(512);
        rd_chk("slow_counter0", CNT_BASE, 2);
        rd_chk("slow_counter0_cleared", CNT_BASE, 0);

        // Fast rate, interval 0 = 256 stage ticks.
        wr(6, 0); wr(1, 4); wr(0, 4);
        ticks(4096);
        rd_chk("fast_counter2", CNT_BASE + 2, 1);

        // Read colliding with increment.
        wr(5, 1); wr(1, 2); wr(0, 2);
        ticks(95);
        cyc(0, 1, CNT_BASE + 1, 0, 1);
        chk("collide_rdata", obs_rd, 5);
        rd_chk("collide_next", CNT_BASE + 1, 1);

        // Read colliding with a wrapping increment: no overflow.
        wr(0, 0); wr(0, 2);
        ticks(255);
        cyc(0, 1, CNT_BASE + 1, 0, 1);
        chk("wrapcol_rdata", obs_rd, 15);
        cyc(0, 1, 3, 0, 0);
        chk("wrapcol_status1", obs_rd & 2, 0);
        rd_chk("wrapcol_next", CNT_BASE + 1, 1);

        // Overflow and irq.
        wr(1, 0); wr(2, 1); wr(4, 1); wr(0, 1);
        ticks(2048);
        rd_chk("ovf_status", 3, 1);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_irq", obs_irq, 1);
        wr(3, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("clr_irq", obs_irq, 0);
        rd_chk("clr_status", 3, 0);
        ticks(2047);
        cyc(1, 0, 3, 1, 1);
        rd_chk("setwins_status", 3, 1);

        // Re-enable behaviour.
        ticks(384);
        wr(0, 1);
        ticks(128);
        rd_chk("reenable_kept", CNT_BASE, 4);
        wr(0, 0); wr(0, 1);
        rd_chk("reenable_cleared", CNT_BASE, 0);
        ticks(127);
        rd_chk("prescaler_restart_a", CNT_BASE, 0);
        ticks(1);
        rd_chk("prescaler_restart_b", CNT_BASE, 1);

        // Randomized traffic against the model.
        wr(1, 7); wr(2, 7); wr(4, 1); wr(5, 2); wr(6, 1); wr(0, 7);
        for (int n = 0; n < 4000; n++) begin
            int a, d;
            bit w, r, t;
            w = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 99) < 12);
            t = ($urandom_range(0, 99) < 85);
            a = $urandom_range(0, 11);
            d = (a >= 4 && a < CNT_BASE) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            cyc(w, r, a, d, t);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
